// File: rtl/weight_tile_scheduler.sv
// weight_tile_scheduler
//   Loads MUL_SIZE x MUL_SIZE weight tiles, one row per cycle, from weight
//   memory into the MAC array's weight buffers. It tracks how many buffers
//   hold a complete tile and hands tiles to the compute controller.
//
//   Build option: define WEIGHT_PREFETCH_EN for two ping-pong buffers. With
//   two buffers, the next tile loads while the array computes on the active
//   one. Without it there is one buffer, and both pointers stay at 0.
//
//   Ports
//     clk_i, rst_i            clock, asynchronous active-high reset
//     start_i                 job start (ignored while busy_o)
//     num_tiles_i/base_addr_i job size and row-0 address, sampled on start
//     wmem_rd_en_o/addr_o     row read request to weight memory
//     wmem_rd_valid_i         a requested row is on the memory bus
//     weight_row_wr_o         write that row into the array buffer
//     weight_row_idx_o        destination row of the write
//     weight_buf_sel_o        buffer being written
//     active_buf_o            buffer the array computes on
//     next_weight_tile_i      active tile consumed
//     compute_weights_rdy_o   at least one full buffer
//     busy_o/done_o           job in progress / job-complete pulse
//     underflow_o             sticky: consume request with no full buffer
module weight_tile_scheduler #(
  parameter int MUL_SIZE = 32,
  parameter int ADDR_W   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [7:0]                  num_tiles_i,
  input  logic [ADDR_W-1:0]           base_addr_i,
  output logic                        wmem_rd_en_o,
  output logic [ADDR_W-1:0]           wmem_addr_o,
  input  logic                        wmem_rd_valid_i,
  output logic                        weight_row_wr_o,
  output logic [$clog2(MUL_SIZE)-1:0] weight_row_idx_o,
  output logic                        weight_buf_sel_o,
  output logic                        active_buf_o,
  input  logic                        next_weight_tile_i,
  output logic                        compute_weights_rdy_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        underflow_o
);

  localparam int ROW_W = $clog2(MUL_SIZE);
`ifdef WEIGHT_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0]       DEPTH_C  = 2'(DEPTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MUL_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT_ROWS, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [7:0]          num_q, num_d;
  // Tile counters are one bit wider than num_tiles so 255+1 does not wrap.
  logic [8:0]          fetch_tile_q, fetch_tile_d;
  logic [8:0]          consumed_q, consumed_d;
  logic [ROW_W-1:0]    issue_row_q, issue_row_d;
  logic [ROW_W-1:0]    ret_row_q, ret_row_d;
  logic [1:0]          fill_q, fill_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                underflow_q, underflow_d;

  logic in_flight, row_wr, tile_done, consume, eval_next;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    num_d        = num_q;
    fetch_tile_d = fetch_tile_q;
    consumed_d   = consumed_q;
    issue_row_d  = issue_row_q;
    ret_row_d    = ret_row_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_en_d      = rd_en_q;
    addr_d       = addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    underflow_d  = underflow_q;
    eval_next    = 1'b0;

    // Returned rows only count while a tile is in flight. This drops rows
    // that were requested before a reset.
    in_flight = (state_q == S_FETCH) || (state_q == S_WAIT_ROWS);
    row_wr    = wmem_rd_valid_i && in_flight;
    tile_done = row_wr && (ret_row_q == LAST_ROW);
    consume   = next_weight_tile_i && (fill_q != 2'd0);

    if (next_weight_tile_i && (fill_q == 2'd0)) underflow_d = 1'b1;

    if (row_wr) ret_row_d = tile_done ? '0 : ret_row_q + 1'b1;
    if (tile_done) begin
      fetch_tile_d = fetch_tile_q + 1'b1;
`ifdef WEIGHT_PREFETCH_EN
      wr_ptr_d = ~wr_ptr_q;
`endif
    end
    if (consume) begin
      consumed_d = consumed_q + 1'b1;
`ifdef WEIGHT_PREFETCH_EN
      rd_ptr_d = ~rd_ptr_q;
`endif
    end

    unique case ({tile_done, consume})
      2'b10:   fill_d = fill_q + 2'd1;
      2'b01:   fill_d = fill_q - 2'd1;
      default: fill_d = fill_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          underflow_d = 1'b0;
          if (num_tiles_i == 8'd0) begin
            done_d = 1'b1;
          end else begin
            base_d       = base_addr_i;
            num_d        = num_tiles_i;
            fetch_tile_d = '0;
            consumed_d   = '0;
            fill_d       = '0;
            issue_row_d  = '0;
            ret_row_d    = '0;
            wr_ptr_d     = 1'b0;
            rd_ptr_d     = 1'b0;
            busy_d       = 1'b1;
            rd_en_d      = 1'b1;
            addr_d       = base_addr_i;
            state_d      = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (issue_row_q == LAST_ROW) begin
          rd_en_d = 1'b0;
          state_d = S_WAIT_ROWS;
          // Zero-latency memory can complete the tile on its last issue.
          eval_next = tile_done;
        end else begin
          issue_row_d = issue_row_q + 1'b1;
          addr_d      = addr_q + 1'b1;
        end
      end
      S_WAIT_ROWS: eval_next = tile_done;
      S_HOLD:      eval_next = 1'b1;
      default:     state_d = S_IDLE;
    endcase

    // Start the next tile when one remains and a buffer is free after this
    // cycle's fill/consume update. Otherwise, wait in HOLD.
    if (eval_next) begin
      if ((fetch_tile_d < {1'b0, num_q}) && (fill_d < DEPTH_C)) begin
        state_d     = S_FETCH;
        rd_en_d     = 1'b1;
        issue_row_d = '0;
        addr_d      = base_q + ADDR_W'(fetch_tile_d) * ADDR_W'(MUL_SIZE);
      end else begin
        state_d = S_HOLD;
      end
    end

    if (busy_q && (consumed_d == {1'b0, num_q})) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      rd_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      num_q        <= '0;
      fetch_tile_q <= '0;
      consumed_q   <= '0;
      issue_row_q  <= '0;
      ret_row_q    <= '0;
      fill_q       <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      num_q        <= num_d;
      fetch_tile_q <= fetch_tile_d;
      consumed_q   <= consumed_d;
      issue_row_q  <= issue_row_d;
      ret_row_q    <= ret_row_d;
      fill_q       <= fill_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underflow_q  <= underflow_d;
    end
  end

  assign wmem_rd_en_o          = rd_en_q;
  assign wmem_addr_o           = addr_q;
  assign weight_row_wr_o       = row_wr;
  assign weight_row_idx_o      = ret_row_q;
  assign weight_buf_sel_o      = wr_ptr_q;
  assign active_buf_o          = rd_ptr_q;
  assign compute_weights_rdy_o = (fill_q != 2'd0);
  assign busy_o                = busy_q;
  assign done_o                = done_q;
  assign underflow_o           = underflow_q;

endmodule

// File: tb/tb_weight_tile_scheduler.sv
// Directed bench for weight_tile_scheduler. The memory model returns each
// requested row two cycles after the read. Expected read addresses and row
// writes are queued when a job is started, and they are checked as the DUT
// produces them.
module tb_weight_tile_scheduler;
  localparam int MS = 32;
`ifdef WEIGHT_PREFETCH_EN
  localparam int DEPTH = 2;
  localparam bit PF    = 1'b1;
`else
  localparam int DEPTH = 1;
  localparam bit PF    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num = '0;
  logic [15:0] base = '0;
  logic        next = 1'b0;
  logic        wmem_rd_valid_i;
  logic        wmem_rd_en_o, weight_row_wr_o, weight_buf_sel_o, active_buf_o;
  logic [15:0] wmem_addr_o;
  logic [4:0]  weight_row_idx_o;
  logic        compute_weights_rdy_o, busy_o, done_o, underflow_o;

  weight_tile_scheduler #(.MUL_SIZE(MS), .ADDR_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_tiles_i(num),
    .base_addr_i(base), .wmem_rd_en_o(wmem_rd_en_o), .wmem_addr_o(wmem_addr_o),
    .wmem_rd_valid_i(wmem_rd_valid_i), .weight_row_wr_o(weight_row_wr_o),
    .weight_row_idx_o(weight_row_idx_o), .weight_buf_sel_o(weight_buf_sel_o),
    .active_buf_o(active_buf_o), .next_weight_tile_i(next),
    .compute_weights_rdy_o(compute_weights_rdy_o), .busy_o(busy_o),
    .done_o(done_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  logic [1:0] mem_pipe = '0;
  always @(posedge clk) mem_pipe <= {mem_pipe[0], wmem_rd_en_o};
  assign wmem_rd_valid_i = mem_pipe[1];

  int n_chk = 0;
  int n_fail = 0;
  int n_reads = 0;
  int cyc = 0;
  int last_done_cyc = -100;
  logic [15:0] addr_q[$];
  logic [5:0]  wr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wmem_rd_en_o) begin
      n_reads++;
      check("read_expected", 32'(addr_q.size() != 0), 32'd1);
      if (addr_q.size() != 0) check("rd_addr", 32'(wmem_addr_o), 32'(addr_q.pop_front()));
    end
    if (weight_row_wr_o) begin
      check("write_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0)
        check("wr_sel_idx", 32'({weight_buf_sel_o, weight_row_idx_o}), 32'(wr_q.pop_front()));
      if (weight_row_idx_o == 5'd31) last_done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [7:0] n);
    base = b; num = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    tick();
    next = 1'b0;
  endtask

  task automatic push_tile(input logic [15:0] b, input int t);
    logic sel;
    sel = PF ? t[0] : 1'b0;
    for (int r = 0; r < MS; r++) begin
      addr_q.push_back(16'(b + 16'(t * MS) + 16'(r)));
      wr_q.push_back({sel, 5'(r)});
    end
  endtask

  task automatic wait_rdy(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (compute_weights_rdy_o) begin ok = 1'b1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(wmem_rd_en_o), 0);
    check({tag, "_addr"}, 32'(wmem_addr_o), 0);
    check({tag, "_wr"}, 32'(weight_row_wr_o), 0);
    check({tag, "_idx"}, 32'(weight_row_idx_o), 0);
    check({tag, "_sel"}, 32'(weight_buf_sel_o), 0);
    check({tag, "_active"}, 32'(active_buf_o), 0);
    check({tag, "_rdy"}, 32'(compute_weights_rdy_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_done"}, 32'(done_o), 0);
    check({tag, "_underflow"}, 32'(underflow_o), 0);
  endtask

  initial begin
    int r0, exp_reads;
    bit found;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    tick(); rst = 1'b0;
    tick();

    // Zero-tile job: done pulse only, no reads
    do_start(16'h1234, 8'd0);
    @(negedge clk);
    check("zero_done", 32'(done_o), 1);
    check("zero_busy", 32'(busy_o), 0);
    tick(); @(negedge clk);
    check("zero_done_one_cycle", 32'(done_o), 0);

    // Single tile at 0x0100
    r0 = n_reads;
    push_tile(16'h0100, 0);
    tick(); do_start(16'h0100, 8'd1);
    @(negedge clk);
    check("single_busy", 32'(busy_o), 1);
    check("single_first_read", 32'(wmem_rd_en_o), 1);
    wait_rdy("single_rdy_timeout");
    check("single_rdy_latency", 32'(cyc - last_done_cyc), 1);
    check("single_reads", 32'(n_reads - r0), 32);
    tick(); pulse_next(); @(negedge clk);
    check("single_done", 32'(done_o), 1);
    check("single_busy_clr", 32'(busy_o), 0);
    check("single_rdy_clr", 32'(compute_weights_rdy_o), 0);

    // Consume with no full buffer: sticky underflow
    tick(); pulse_next(); @(negedge clk);
    check("underflow_set", 32'(underflow_o), 1);
    repeat (5) tick();
    @(negedge clk);
    check("underflow_sticky", 32'(underflow_o), 1);

    // Address wrap at 0xFFF0; start clears underflow
    push_tile(16'hFFF0, 0);
    tick(); do_start(16'hFFF0, 8'd1);
    @(negedge clk);
    check("underflow_cleared", 32'(underflow_o), 0);
    wait_rdy("wrap_rdy_timeout");
    tick(); pulse_next(); @(negedge clk);
    check("wrap_done", 32'(done_o), 1);

    // Four tiles, consumed one at a time after the fetcher settles
    r0 = n_reads;
    for (int t = 0; t < 4; t++) push_tile(16'h2000, t);
    tick(); do_start(16'h2000, 8'd4);
    for (int t = 0; t < 4; t++) begin
      repeat (100) tick();
      @(negedge clk);
      exp_reads = MS * (t + DEPTH);
      if (exp_reads > 4 * MS) exp_reads = 4 * MS;
      check("multi_reads", 32'(n_reads - r0), 32'(exp_reads));
      check("multi_rdy", 32'(compute_weights_rdy_o), 1);
      check("multi_active", 32'(active_buf_o), PF ? 32'(t % 2) : 32'd0);
      tick(); pulse_next(); @(negedge clk);
      check("multi_done", 32'(done_o), 32'(t == 3));
    end

`ifdef WEIGHT_PREFETCH_EN
    // Tile completion and consume in the same cycle
    push_tile(16'h5000, 0);
    push_tile(16'h5000, 1);
    tick(); do_start(16'h5000, 8'd2);
    wait_rdy("same_rdy_timeout");
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (weight_row_wr_o && weight_buf_sel_o && weight_row_idx_o == 5'd30) begin
        found = 1'b1; break;
      end
    end
    check("same_row30_seen", 32'(found), 1);
    tick(); pulse_next(); @(negedge clk);
    check("same_rdy_held", 32'(compute_weights_rdy_o), 1);
    check("same_active_toggled", 32'(active_buf_o), 1);
    check("same_sel_toggled", 32'(weight_buf_sel_o), 0);
    check("same_busy", 32'(busy_o), 1);
    tick(); pulse_next(); @(negedge clk);
    check("same_done", 32'(done_o), 1);
`endif

    // Reset during FETCH at row 10
    for (int r = 0; r <= 10; r++) addr_q.push_back(16'h0300 + 16'(r));
    for (int r = 0; r <= 8; r++) wr_q.push_back({1'b0, 5'(r)});
    tick(); do_start(16'h0300, 8'd1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wmem_rd_en_o && wmem_addr_o == 16'h030A) begin found = 1'b1; break; end
    end
    check("rst_row10_seen", 32'(found), 1);
    #2 rst = 1'b1;
    #1 check("rst_valid_present", 32'(wmem_rd_valid_i), 1);
    check_idle_outputs("midrst");
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_queues_drained", 32'(addr_q.size() + wr_q.size()), 0);
    tick();
    push_tile(16'h0400, 0);
    do_start(16'h0400, 8'd1);
    wait_rdy("post_rst_rdy_timeout");
    tick(); pulse_next(); @(negedge clk);
    check("post_rst_done", 32'(done_o), 1);

    repeat (5) tick();
    check("final_queues_empty", 32'(addr_q.size() + wr_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
